// File: rtl/instr_issue.sv
// Purpose: dual-issue decode/route stage. It classifies a fetched pair to the even and odd pipes and splits conflicting pairs.
// Latency: 1 cycle from a presented pair to the slot outputs; the second half of a split pair arrives 1 cycle later.
// Backpressure: dep_stall_instr2 holds fetch during a split and during hazard_stall; flush drops everything in flight.
// Ports: clk/reset (async, active-high); fetch_valid, fetch_pc, instr1, instr2 come from fetch;
//        hazard_stall and flush come from downstream; even_*/odd_* are the registered issue slots;
//        dep_stall_instr2 is the combinational fetch hold.

package spu_isa_pkg;

   // The odd pipe takes lnop, loads/stores, branches and the quadword permute/shift/rotate family.
   function automatic logic is_odd_pipe(input logic [10:0] op);
      logic [7:0] op8;
      logic [8:0] op9;
      logic       odd;
      op8 = op[10:3];
      op9 = op[10:2];
      odd = 1'b0;
      if (op == 11'h001)                    odd = 1'b1;   // lnop
      if (op8 == 8'h34 || op8 == 8'h24)     odd = 1'b1;   // lqd, stqd
      if (op[10:7] == 4'hB)                 odd = 1'b1;   // shufb
      if (op9 == 9'h075 || op9 == 9'h07D)   odd = 1'b1;   // cbx..cdx, cbd..cdd
      if (op8 == 8'h3B || op8 == 8'h3F)     odd = 1'b1;   // quadword shifts/rotates
      case (op9)
         9'h040, 9'h041, 9'h042, 9'h044, 9'h046, 9'h047,
         9'h060, 9'h061, 9'h062, 9'h064, 9'h065, 9'h066, 9'h067: odd = 1'b1;
         default: ;
      endcase
      case (op)
         11'h1C4, 11'h144, 11'h128, 11'h129, 11'h12A, 11'h12B,
         11'h1A8, 11'h1A9, 11'h1AA, 11'h1AB, 11'h1B0, 11'h1B1,
         11'h1B2, 11'h1B4, 11'h1B5, 11'h1B6, 11'h1F0: odd = 1'b1;
         default: ;
      endcase
      return odd;
   endfunction

   // Stores, non-linking branches and the two no-ops leave rt untouched.
   function automatic logic writes_rt(input logic [10:0] op);
      logic wr;
      wr = 1'b1;
      if (op == 11'h001 || op == 11'h201) wr = 1'b0;   // lnop, nop
      if (op[10:3] == 8'h24)              wr = 1'b0;   // stqd
      case (op[10:2])
         9'h040, 9'h041, 9'h042, 9'h044, 9'h046, 9'h047, 9'h060, 9'h064: wr = 1'b0;
         default: ;
      endcase
      case (op)
         11'h144, 11'h128, 11'h129, 11'h12A, 11'h12B, 11'h1A8, 11'h1AA: wr = 1'b0;
         default: ;
      endcase
      return wr;
   endfunction

endpackage

module instr_issue #(
   parameter int               WORD     = 32,
   parameter logic [0:WORD-1]  NOP_EVEN = 32'h4020_0000,
   parameter logic [0:WORD-1]  NOP_ODD  = 32'h0020_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fetch_valid,
   input  logic [0:WORD-1]    fetch_pc,
   input  logic [0:WORD-1]    instr1,
   input  logic [0:WORD-1]    instr2,
   input  logic               hazard_stall,
   input  logic               flush,
   output logic               dep_stall_instr2,
   output logic [0:WORD-1]    even_instr,
   output logic [0:WORD-1]    odd_instr,
   output logic [0:WORD-1]    even_pc,
   output logic [0:WORD-1]    odd_pc,
   output logic               even_valid,
   output logic               odd_valid
);

   typedef enum logic {PAIR, SECOND} state_t;

   typedef struct packed {
      logic [0:WORD-1] instr;
      logic [0:WORD-1] pc;
      logic            valid;
   } slot_t;

   localparam slot_t FILL_E = '{instr: NOP_EVEN, pc: '0, valid: 1'b0};
   localparam slot_t FILL_O = '{instr: NOP_ODD,  pc: '0, valid: 1'b0};

   state_t state_q, state_nxt;
   slot_t  even_q, even_nxt;
   slot_t  odd_q, odd_nxt;
   logic   dep_stall;

   logic            empty1, empty2, odd1, odd2, raw, conflict;
   logic [0:WORD-1] pc2;

   assign empty1 = (instr1 == NOP_EVEN) || (instr1 == NOP_ODD);
   assign empty2 = (instr2 == NOP_EVEN) || (instr2 == NOP_ODD);
   assign odd1   = spu_isa_pkg::is_odd_pipe(instr1[0:10]);
   assign odd2   = spu_isa_pkg::is_odd_pipe(instr2[0:10]);
   assign pc2    = fetch_pc + WORD'(4);

   // Conservative RAW: any of instr2's register fields matching instr1's target counts.
   assign raw = !empty1 && spu_isa_pkg::writes_rt(instr1[0:10]) &&
                ((instr2[11:17] == instr1[25:31]) ||
                 (instr2[18:24] == instr1[25:31]) ||
                 (instr2[25:31] == instr1[25:31]));

   assign conflict = !empty1 && !empty2 && ((odd1 == odd2) || raw);

   always_comb begin
      even_nxt  = even_q;
      odd_nxt   = odd_q;
      state_nxt = state_q;
      dep_stall = 1'b0;
      if (flush) begin
         even_nxt  = FILL_E;
         odd_nxt   = FILL_O;
         state_nxt = PAIR;
      end else if (hazard_stall) begin
         // Everything holds; the split decision is redone once the stall clears.
         dep_stall = 1'b1;
      end else if (state_q == SECOND) begin
         // Fetch still presents the same pair; only the deferred instr2 goes out.
         even_nxt  = FILL_E;
         odd_nxt   = FILL_O;
         state_nxt = PAIR;
         if (!empty2) begin
            if (odd2) odd_nxt  = '{instr: instr2, pc: pc2, valid: 1'b1};
            else      even_nxt = '{instr: instr2, pc: pc2, valid: 1'b1};
         end
      end else begin
         even_nxt = FILL_E;
         odd_nxt  = FILL_O;
         if (fetch_valid) begin
            if (!empty1) begin
               if (odd1) odd_nxt  = '{instr: instr1, pc: fetch_pc, valid: 1'b1};
               else      even_nxt = '{instr: instr1, pc: fetch_pc, valid: 1'b1};
            end
            if (conflict) begin
               dep_stall = 1'b1;
               state_nxt = SECOND;
            end else if (!empty2) begin
               // Non-conflicting pairs always land in different pipes, so no overwrite here.
               if (odd2) odd_nxt  = '{instr: instr2, pc: pc2, valid: 1'b1};
               else      even_nxt = '{instr: instr2, pc: pc2, valid: 1'b1};
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= PAIR;
         even_q  <= FILL_E;
         odd_q   <= FILL_O;
      end else begin
         state_q <= state_nxt;
         even_q  <= even_nxt;
         odd_q   <= odd_nxt;
      end
   end

   // Forced low during reset so fetch never sees a hold while the stage is being cleared.
   assign dep_stall_instr2 = dep_stall && !reset;

   assign even_instr = even_q.instr;
   assign even_pc    = even_q.pc;
   assign even_valid = even_q.valid;
   assign odd_instr  = odd_q.instr;
   assign odd_pc     = odd_q.pc;
   assign odd_valid  = odd_q.valid;

endmodule
